regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 62 ++++++
 rtl/regfile_sb.sv | 108 ++++++++++
 tb/tb_regfile_sb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and byte-strobe merge helper for the register file
package regfile_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int NREG_DEFAULT = 32;

   // One strobe bit selects between the stored byte and the incoming byte.
   function automatic logic [7:0] strb_merge(input logic [7:0] old_byte,
                                             input logic [7:0] new_byte,
                                             input logic       strb);
      return strb ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-producer busy vector, operand stalls and busy popcount
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NREG = NREG_DEFAULT,
   parameter  int SW   = XLEN_DEFAULT / 8,
   localparam int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] rs1,
   input  logic [AW-1:0] rs2,
   input  logic          wea,
   input  logic [AW-1:0] rda,
   input  logic [SW-1:0] wstrba,
   input  logic          web,
   input  logic [AW-1:0] rdb,
   input  logic [SW-1:0] wstrbb,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_rd,
   output logic          stall1,
   output logic          stall2,
   output logic [AW:0]   busy_cnt
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;
   logic [AW:0]     cnt_next;
   logic            wr_a;
   logic            wr_b;

   // A write with an all-zero strobe changes nothing, so it resolves nothing either.
   assign wr_a = wea && (|wstrba);
   assign wr_b = web && (|wstrbb);

   always_comb begin
      busy_next = busy;
      if (wr_a) busy_next[rda] = 1'b0;
      if (wr_b) busy_next[rdb] = 1'b0;
      // A new issue supersedes any producer completing on the same edge.
      if (iss_valid && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
      cnt_next = '0;
      for (int i = 0; i < NREG; i++) begin
         cnt_next = cnt_next + (AW+1)'(busy_next[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= cnt_next;
      end
   end

   // busy[0] is never set, so x0 reads never stall.
   assign stall1 = !reset && busy[rs1] && !(wr_a && (rda == rs1)) && !(wr_b && (rdb == rs1));
   assign stall2 = !reset && busy[rs2] && !(wr_a && (rda == rs2)) && !(wr_b && (rdb == rs2));

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - dual-write byte-strobed register file with write-first reads and scoreboard
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int XLEN = XLEN_DEFAULT,
   parameter  int NREG = NREG_DEFAULT,
   localparam int AW   = $clog2(NREG),
   localparam int SW   = XLEN / 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rv1,
   output logic [XLEN-1:0] rv2,
   input  logic            wea,
   input  logic [AW-1:0]   rda,
   input  logic [SW-1:0]   wstrba,
   input  logic [XLEN-1:0] wdataa,
   input  logic            web,
   input  logic [AW-1:0]   rdb,
   input  logic [SW-1:0]   wstrbb,
   input  logic [XLEN-1:0] wdatab,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            stall1,
   output logic            stall2,
   input  logic [AW-1:0]   dbg_addr,
   output logic [XLEN-1:0] dbg_data,
   output logic [AW:0]     busy_cnt
);

   logic [XLEN-1:0] regs      [NREG];
   logic [XLEN-1:0] regs_next [NREG];

   function automatic logic [XLEN-1:0] merge_word(input logic [XLEN-1:0] old_w,
                                                  input logic [XLEN-1:0] new_w,
                                                  input logic [SW-1:0]   strb);
      logic [XLEN-1:0] w;
      for (int b = 0; b < SW; b++) begin
         w[8*b +: 8] = strb_merge(old_w[8*b +: 8], new_w[8*b +: 8], strb[b]);
      end
      return w;
   endfunction

   // Port B is merged after port A so its strobed bytes win on a shared target.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_next[i] = regs[i];
         if (i != 0) begin
            if (wea && (rda == AW'(i))) regs_next[i] = merge_word(regs_next[i], wdataa, wstrba);
            if (web && (rdb == AW'(i))) regs_next[i] = merge_word(regs_next[i], wdatab, wstrbb);
         end
      end
      regs_next[0] = '0;
   end

   always_comb begin
      rv1 = '0;
      if (!reset && (rs1 != '0)) begin
         rv1 = regs[rs1];
         if (wea && (rda == rs1)) rv1 = merge_word(rv1, wdataa, wstrba);
         if (web && (rdb == rs1)) rv1 = merge_word(rv1, wdatab, wstrbb);
      end
   end

   always_comb begin
      rv2 = '0;
      if (!reset && (rs2 != '0)) begin
         rv2 = regs[rs2];
         if (wea && (rda == rs2)) rv2 = merge_word(rv2, wdataa, wstrba);
         if (web && (rdb == rs2)) rv2 = merge_word(rv2, wdatab, wstrbb);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         dbg_data <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) regs[i] <= regs_next[i];
         // Debug readout samples the pre-edge stored value.
         dbg_data <= regs[dbg_addr];
      end
   end

   regfile_scoreboard #(
      .NREG (NREG),
      .SW   (SW)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .rs1       (rs1),
      .rs2       (rs2),
      .wea       (wea),
      .rda       (rda),
      .wstrba    (wstrba),
      .web       (web),
      .rdb       (rdb),
      .wstrbb    (wstrbb),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .stall1    (stall1),
      .stall2    (stall2),
      .busy_cnt  (busy_cnt)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized and directed self-checking bench for regfile_sb
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int SW   = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [AW-1:0]   rs1, rs2, rda, rdb, iss_rd, dbg_addr;
   logic [XLEN-1:0] rv1, rv2, wdataa, wdatab, dbg_data;
   logic [SW-1:0]   wstrba, wstrbb;
   logic            wea, web, iss_valid, stall1, stall2;
   logic [AW:0]     busy_cnt;

   int n_checks = 0;
   int n_errors = 0;

   logic [XLEN-1:0] model  [NREG];
   bit              busy_m [NREG];

   regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
      .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rv1(rv1), .rv2(rv2),
      .wea(wea), .rda(rda), .wstrba(wstrba), .wdataa(wdataa),
      .web(web), .rdb(rdb), .wstrbb(wstrbb), .wdatab(wdatab),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .stall1(stall1), .stall2(stall2),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] seen(input logic [AW-1:0] r);
      logic [XLEN-1:0] v;
      if (r == 0) return '0;
      v = model[r];
      for (int b = 0; b < SW; b++) begin
         if (web && rdb == r && wstrbb[b])      v[8*b +: 8] = wdatab[8*b +: 8];
         else if (wea && rda == r && wstrba[b]) v[8*b +: 8] = wdataa[8*b +: 8];
      end
      return v;
   endfunction

   function automatic bit written(input logic [AW-1:0] r);
      return (wea && rda == r && wstrba != 0) || (web && rdb == r && wstrbb != 0);
   endfunction

   function automatic bit exp_stall(input logic [AW-1:0] r);
      return (r != 0) && busy_m[r] && !written(r);
   endfunction

   task automatic idle();
      wea = 0; rda = 0; wstrba = 0; wdataa = 0;
      web = 0; rdb = 0; wstrbb = 0; wdatab = 0;
      iss_valid = 0; iss_rd = 0;
   endtask

   task automatic clear_model();
      for (int r = 0; r < NREG; r++) begin
         model[r] = '0;
         busy_m[r] = 0;
      end
   endtask

   // Check combinational outputs mid-cycle, then registered outputs just after the edge.
   task automatic step();
      logic [XLEN-1:0] nxt [NREG];
      logic [XLEN-1:0] exp_dbg;
      int cnt;
      @(negedge clk);
      check("rv1", rv1, seen(rs1));
      check("rv2", rv2, seen(rs2));
      check("stall1", stall1, exp_stall(rs1));
      check("stall2", stall2, exp_stall(rs2));
      for (int r = 0; r < NREG; r++) nxt[r] = seen(AW'(r));
      exp_dbg = model[dbg_addr];
      for (int r = 0; r < NREG; r++) if (written(AW'(r))) busy_m[r] = 0;
      if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1;
      @(posedge clk);
      #1;
      for (int r = 0; r < NREG; r++) model[r] = nxt[r];
      cnt = 0;
      for (int r = 0; r < NREG; r++) cnt += int'(busy_m[r]);
      check("busy_cnt", busy_cnt, cnt);
      check("dbg_data", dbg_data, exp_dbg);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      return ($urandom % 2 == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG-1));
   endfunction

   initial begin
      reset = 1; idle(); rs1 = 0; rs2 = 0; dbg_addr = 0;
      clear_model();
      #1;
      check("reset_busy_cnt", busy_cnt, 0);
      check("reset_dbg_data", dbg_data, 0);
      rs1 = 5; #1;
      check("reset_rv1", rv1, 0);
      check("reset_stall1", stall1, 0);
      repeat (2) @(posedge clk);
      #2 reset = 0;

      // same-cycle bypass, then registered debug readout
      wea = 1; rda = 5; wstrba = 4'hF; wdataa = 32'hDEADBEEF; rs1 = 5;
      #1 check("bypass_rv1", rv1, 32'hDEADBEEF);
      step();
      idle(); dbg_addr = 5;
      step();
      check("dbg_x5", dbg_data, 32'hDEADBEEF);

      // x0 is hardwired
      wea = 1; rda = 0; wstrba = 4'hF; wdataa = 32'h1234; rs1 = 0;
      step();
      idle(); #1;
      check("x0_rv1", rv1, 0);
      check("x0_stall1", stall1, 0);
      check("x0_busy_cnt", busy_cnt, 0);

      // dual-port byte merge on one register
      wea = 1; rda = 3; wstrba = 4'hF; wdataa = 32'h11223344;
      step();
      wea = 1; rda = 3; wstrba = 4'b0011; wdataa = 32'hAAAAAAAA;
      web = 1; rdb = 3; wstrbb = 4'b0110; wdatab = 32'hBBBBBBBB; rs2 = 3;
      step();
      idle(); rs1 = 3; #1;
      check("merge_x3", rv1, 32'h11BBBBAA);

      // issue then resolve
      iss_valid = 1; iss_rd = 7; rs1 = 7;
      step();
      idle(); #1;
      check("iss7_busy_cnt", busy_cnt, 1);
      check("iss7_stall1", stall1, 1);
      wea = 1; rda = 7; wstrba = 4'h1; wdataa = 32'h55;
      #1 check("wr7_stall1", stall1, 0);
      step();
      idle(); #1;
      check("wr7_busy_cnt", busy_cnt, 0);

      // simultaneous issue and write: set wins
      iss_valid = 1; iss_rd = 9; wea = 1; rda = 9; wstrba = 4'hF; wdataa = 32'hCAFEF00D;
      step();
      idle(); rs1 = 9; #1;
      check("iss9_busy_cnt", busy_cnt, 1);
      check("iss9_stall1", stall1, 1);
      check("iss9_data", rv1, 32'hCAFEF00D);

      for (int n = 0; n < 1500; n++) begin
         wea = $urandom_range(0, 1); rda = rand_addr(); wstrba = SW'($urandom); wdataa = $urandom;
         web = $urandom_range(0, 1); rdb = rand_addr(); wstrbb = SW'($urandom); wdatab = $urandom;
         iss_valid = ($urandom % 3 == 0); iss_rd = rand_addr();
         rs1 = rand_addr(); rs2 = rand_addr(); dbg_addr = rand_addr();
         step();
      end

      // three issues, then asynchronous reset mid-cycle
      idle();
      iss_valid = 1; iss_rd = 2; step();
      iss_rd = 4; step();
      iss_rd = 6; step();
      idle();
      #2 reset = 1;
      #1;
      check("areset_busy_cnt", busy_cnt, 0);
      check("areset_dbg_data", dbg_data, 0);
      #1 reset = 0;
      clear_model();
      for (int r = 0; r < NREG; r++) begin
         rs1 = AW'(r); #1;
         check("areset_rv1", rv1, 0);
         check("areset_stall1", stall1, 0);
      end
      for (int n = 0; n < 20; n++) begin
         wea = $urandom_range(0, 1); rda = rand_addr(); wstrba = SW'($urandom); wdataa = $urandom;
         iss_valid = $urandom_range(0, 1); iss_rd = rand_addr();
         rs1 = rand_addr(); rs2 = rand_addr(); dbg_addr = rand_addr();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
